// File: rtl/conv_sr_controller.sv
// conv_sr_controller
// Frame sequencer for a convolution shift-register window. Accepts a raster
// pixel stream, drives the datapath shift enable / column byte, tracks the
// scan position and flags complete KERNEL x KERNEL in-image neighbourhoods
// to the downstream MAC array through a valid/ready handshake.
module conv_sr_controller #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 6,
  parameter int KERNEL = 3,
  parameter int COL_W  = $clog2(IMG_W),
  parameter int ROW_W  = $clog2(IMG_H)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             sr_enable,
  output logic             sr_shift_row_up,
  output logic [7:0]       sr_column_in,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_t;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_OFF = COL_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] ROW_OFF = ROW_W'(KERNEL - 1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic             win_valid_r;
  logic [ROW_W-1:0] win_row_r;
  logic [COL_W-1:0] win_col_r;
  logic             done_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             last_pixel_s;
  logic             win_hit_s;
  logic             retire_s;
  logic             frame_end_s;

  // Handshake and position decode; a pending window blocks shifting so the
  // datapath window stays stable until it is consumed.
  always_comb begin
    in_ready_s   = (state_r == ST_RUN) && !(win_valid_r && !win_ready);
    accept_s     = in_valid && in_ready_s;
    last_pixel_s = (row_r == ROW_MAX) && (col_r == COL_MAX);
    win_hit_s    = (row_r >= ROW_OFF) && (col_r >= COL_OFF);
    retire_s     = win_valid_r && win_ready;
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_next_s = state_r;
    frame_end_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && last_pixel_s) begin
          state_next_s = ST_LAST;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_LAST: begin
        // Wait for the final window (if any) to drain before finishing.
        if (!win_valid_r || win_ready) begin
          state_next_s = ST_IDLE;
          frame_end_s  = 1'b1;
        end else begin
          state_next_s = ST_LAST;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        frame_end_s  = 1'b0;
      end
    endcase
  end

  // State register and one-cycle frame-done pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      done_r  <= frame_end_s;
    end
  end

  // Raster position of the next pixel; cleared at frame start.
  always_ff @(posedge clock) begin
    if (!reset) begin
      row_r <= '0;
      col_r <= '0;
    end else if ((state_r == ST_IDLE) && start) begin
      row_r <= '0;
      col_r <= '0;
    end else if (accept_s) begin
      if (col_r == COL_MAX) begin
        col_r <= '0;
        row_r <= row_r + ROW_ONE;
      end else begin
        col_r <= col_r + COL_ONE;
      end
    end
  end

  // Window status: loaded by each accepted pixel, cleared when consumed
  // without a new pixel. Rows below KERNEL-1 and row-straddling columns are
  // never flagged, which also keeps previous-frame lines out of windows.
  always_ff @(posedge clock) begin
    if (!reset) begin
      win_valid_r <= 1'b0;
      win_row_r   <= '0;
      win_col_r   <= '0;
    end else if (accept_s) begin
      win_valid_r <= win_hit_s;
      if (win_hit_s) begin
        win_row_r <= row_r - ROW_OFF;
        win_col_r <= col_r - COL_OFF;
      end
    end else if (retire_s) begin
      win_valid_r <= 1'b0;
    end
  end

  assign in_ready        = in_ready_s;
  assign sr_enable       = accept_s;
  assign sr_shift_row_up = 1'b0;
  assign sr_column_in    = in_data;
  assign win_valid       = win_valid_r;
  assign win_row         = win_row_r;
  assign win_col         = win_col_r;
  assign busy            = (state_r != ST_IDLE);
  assign done            = done_r;

endmodule

// File: tb/tb_conv_sr_controller.sv
// Self-checking bench for conv_sr_controller: a behavioural frame model
// predicts handshake outputs each cycle and a queue holds expected windows.
module tb_conv_sr_controller;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int KERNEL = 3;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWIN   = (IMG_W - KERNEL + 1) * (IMG_H - KERNEL + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'd0;
  logic             win_ready = 1'b0;
  logic             in_ready;
  logic             sr_enable;
  logic             sr_shift_row_up;
  logic [7:0]       sr_column_in;
  logic             win_valid;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic             busy;
  logic             done;

  conv_sr_controller #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sr_enable(sr_enable), .sr_shift_row_up(sr_shift_row_up),
    .sr_column_in(sr_column_in),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_row(win_row), .win_col(win_col),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  bit m_run  = 1'b0;
  bit m_last = 1'b0;
  bit m_done = 1'b0;
  int m_idx  = 0;
  int win_q[$];
  int n_win  = 0;
  int n_done = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare against model, advance model.
  task automatic step(input logic st, input logic v, input logic wr);
    logic       acc;
    logic       exp_rdy;
    logic       pend;
    logic       nd;
    logic [7:0] data;
    int         r;
    int         c;
    @(negedge clock);
    data      = m_idx[7:0];
    start     = st;
    in_valid  = v;
    win_ready = wr;
    in_data   = data;
    #1;
    pend    = (win_q.size() > 0);
    exp_rdy = m_run && !(pend && !wr);
    acc     = v && exp_rdy;
    nd      = m_last && (!pend || wr);
    check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
    check_val("sr_enable", 32'(sr_enable), 32'(acc));
    check_val("sr_column_in", 32'(sr_column_in), 32'(data));
    check_val("sr_shift_row_up", 32'(sr_shift_row_up), 32'd0);
    check_val("win_valid", 32'(win_valid), 32'(pend));
    check_val("busy", 32'(busy), 32'(m_run || m_last));
    check_val("done", 32'(done), 32'(m_done));
    if (m_done) n_done++;
    if (pend) begin
      check_val("win_row", 32'(win_row), 32'(win_q[0] / 256));
      check_val("win_col", 32'(win_col), 32'(win_q[0] % 256));
      if (wr) begin
        void'(win_q.pop_front());
        n_win++;
      end
    end
    if (acc) begin
      r = m_idx / IMG_W;
      c = m_idx % IMG_W;
      if (r >= KERNEL - 1 && c >= KERNEL - 1)
        win_q.push_back((r - KERNEL + 1) * 256 + (c - KERNEL + 1));
      if (m_idx == NPIX - 1) begin
        m_run  = 1'b0;
        m_last = 1'b1;
      end
      m_idx++;
    end
    if (st && !m_run && !m_last) begin
      m_run = 1'b1;
      m_idx = 0;
    end
    m_done = nd;
    if (nd) m_last = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    win_ready = 1'b0;
    @(negedge clock);
    #1;
    check_val("rst_win_valid", 32'(win_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_win_row", 32'(win_row), 32'd0);
    check_val("rst_win_col", 32'(win_col), 32'd0);
    reset  = 1'b1;
    m_run  = 1'b0;
    m_last = 1'b0;
    m_done = 1'b0;
    m_idx  = 0;
    win_q.delete();
  endtask

  // mode 0: streaming, 1: 5-cycle stall at first window, 2: random with
  // start pulses mid-frame. abort_at >= 0 stops after that pixel is accepted.
  task automatic run_frame(input int mode, input int abort_at);
    int   guard;
    int   stall;
    logic v;
    logic wr;
    logic st;
    guard  = 0;
    stall  = 0;
    n_win  = 0;
    n_done = 0;
    step(1'b1, 1'b0, 1'b1);
    while (guard < 800) begin
      if (abort_at >= 0 && m_idx == abort_at + 1) break;
      guard++;
      st = 1'b0;
      v  = 1'b1;
      wr = 1'b1;
      case (mode)
        1: begin
          if (win_q.size() > 0 && stall < 5) begin
            wr = 1'b0;
            stall++;
          end
        end
        2: begin
          v  = 1'($urandom_range(0, 1));
          wr = 1'($urandom_range(0, 1));
          st = (m_idx == 10) || (m_idx == 40);
        end
        default: ;
      endcase
      step(st, v, wr);
      if (n_done > 0 && !m_run && !m_last && !m_done) break;
    end
    if (abort_at < 0) begin
      check_val("frame_timeout", 32'(guard < 800), 32'd1);
      if (mode == 0) check_val("frame_cycles", 32'(guard), 32'd50);
      repeat (3) step(1'b0, 1'b0, 1'b1);
      check_val("window_count", 32'(n_win), 32'(NWIN));
      check_val("done_count", 32'(n_done), 32'd1);
    end
  endtask

  initial begin
    apply_reset();
    run_frame(0, -1);
    run_frame(1, -1);
    run_frame(2, -1);
    run_frame(0, 30);
    apply_reset();
    run_frame(0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
